bcd_display_scanner: RTL



---
 rtl/display_pkg.sv | 60 ++++++
 rtl/bin2bcd_seq.sv | 104 ++++++++++
 rtl/bcd_display_scanner.sv | 95 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the BCD display scanner.
//
// Contents:
//   VALUE_W / NUM_DIGITS / BCD_W  - datapath sizes
//   conv_state_e                  - conversion FSM states
//   SEG_0..SEG_9, SEG_BLANK       - active-low {g,f,e,d,c,b,a} patterns
//   seg_encode()                  - BCD nibble to segment pattern
//   add3_adjust()                 - double-dabble nibble correction
package display_pkg;

    localparam int VALUE_W    = 13;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int BITCNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Nibbles above 9 cannot come out of a finished conversion; they map
    // to blank so a corrupted digit is visibly dark rather than misleading.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // A nibble >= 5 would become >= 10 after the next shift, so it is
    // pre-biased by 3 to make the carry land in the next decimal digit.
    function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 13-bit binary to 4-digit BCD converter (shift-add-3).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   value     in   13-bit unsigned value to convert
//   bcd       out  last completed result, {thousands,hundreds,tens,units}
//   busy      out  high while state != IDLE (pure register decode)
//   conv_done out  one-cycle pulse in the cycle after bcd updates
//
// A change of value sampled in IDLE starts a conversion: 13 CONV cycles
// then one DONE cycle, so bcd updates 14 edges after the sampling edge.
// value is not looked at during CONV/DONE; the next IDLE cycle compares
// against last_value again, so the final stable value is always shown.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    output logic [BCD_W-1:0]   bcd,
    output logic               busy,
    output logic               conv_done
);

    conv_state_e         state_q,      state_d;
    logic [VALUE_W-1:0]  shreg_q,      shreg_d;
    logic [VALUE_W-1:0]  last_value_q, last_value_d;
    logic [BCD_W-1:0]    acc_q,        acc_d;
    logic [BITCNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [BCD_W-1:0]    bcd_q,        bcd_d;
    logic                done_q,       done_d;

    logic [BCD_W-1:0]    acc_adj;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            acc_adj[4*i +: 4] = add3_adjust(acc_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        last_value_d = last_value_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        bcd_d        = bcd_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (value != last_value_q) begin
                    shreg_d      = value;
                    last_value_d = value;
                    acc_d        = '0;
                    bit_cnt_d    = BITCNT_W'(VALUE_W);
                    state_d      = CONV;
                end
            end
            CONV: begin
                // Adjust, then shift {acc, shreg} left by one as a unit.
                {acc_d, shreg_d} = {acc_adj[BCD_W-2:0], shreg_q, 1'b0};
                bit_cnt_d        = bit_cnt_q - 1'b1;
                if (bit_cnt_q == BITCNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            last_value_q <= '0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            bcd_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            last_value_q <= last_value_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            bcd_q        <= bcd_d;
            done_q       <= done_d;
        end
    end

    assign bcd       = bcd_q;
    assign busy      = (state_q != IDLE);
    assign conv_done = done_q;

endmodule

// File: rtl/bcd_display_scanner.sv
// 13-bit value to 4-digit multiplexed common-anode 7-segment display.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   LZ_BLANK     1 = blank leading zeros (units never blanked)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   value     in   13-bit unsigned value from the selector
//   seg       out  {g,f,e,d,c,b,a}, active-low, registered
//   anode     out  one-hot active-low digit enable, bit 0 = units
//   busy      out  conversion in progress
//   conv_done out  one-cycle pulse after the digits update
//
// The refresh scan free-runs regardless of conversion activity; the
// digits shown are always those of the last completed conversion.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    output logic [6:0]         seg,
    output logic [3:0]         anode,
    output logic               busy,
    output logic               conv_done
);

    localparam int RCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

    logic [BCD_W-1:0]  bcd;
    logic [3:0]        digit [NUM_DIGITS];
    logic [3:0]        blank;
    logic              wrap;

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [1:0]        sel_q,  sel_d;
    logic [6:0]        seg_q,  seg_d;

    bin2bcd_seq u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .bcd       (bcd),
        .busy      (busy),
        .conv_done (conv_done)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] = bcd[4*i +: 4];
        end
    end

    // A digit is a leading zero when it and everything above it is zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (digit[3] == 4'd0);
        blank[2] = blank[3] && (digit[2] == 4'd0);
        blank[1] = blank[2] && (digit[1] == 4'd0);
        if (!LZ_BLANK) begin
            blank = 4'b0000;
        end
    end

    // seg is computed from the next select so it changes on the same
    // edge as the anode derived from sel_q.
    always_comb begin
        wrap   = (rcnt_q == RCNT_LAST);
        rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
        sel_d  = wrap ? sel_q + 2'd1 : sel_q;
        seg_d  = blank[sel_d] ? SEG_BLANK : seg_encode(digit[sel_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            sel_q  <= 2'd0;
            seg_q  <= SEG_0;
        end else begin
            rcnt_q <= rcnt_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign anode = ~(4'b0001 << sel_q);
    assign seg   = seg_q;

endmodule
